// File: rtl/instr_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : instr_step_driver
// Purpose  : Holds a small writable program and steps it into a processor's
//            front-panel interface one instruction at a time: the word goes
//            on switches, then a button[1] step pulse with setup/pulse/gap
//            timing. leds is captured after every store instruction.
// Revision : 1.0 - initial release
// ============================================================================
module instr_step_driver #(
  parameter int AW        = 3,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic [7:0]    switches,
  output logic [1:0]    button,
  input  logic [3:0]    leds,
  output logic          busy,
  output logic          done,
  output logic          led_valid,
  output logic [3:0]    led_data
);

  localparam int DEPTH = 2 ** AW;
  localparam int MAXC  = (SETUP_CYC > PULSE_CYC) ?
                         ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                         ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [AW:0]   c_len_max  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] c_setup_ld = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] c_pulse_ld = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] c_gap_ld   = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_GAP    = 3'd3,
    S_SAMPLE = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_last_sw;
  logic [3:0]    r_led_data;
  logic          w_led_load;
  logic [7:0]    w_instr;
  logic          w_is_store;
  logic          w_last;
  logic          w_cnt_zero;
  logic          w_active;
  logic [AW:0]   w_len_clamped;

  assign w_instr       = r_mem[r_pc];
  assign w_is_store    = (w_instr[7:6] == 2'b01);
  assign w_last        = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_len_clamped = (prog_len > c_len_max) ? c_len_max : prog_len;
  assign w_active      = (r_state == S_SETUP) || (r_state == S_PULSE) ||
                         (r_state == S_GAP)   || (r_state == S_SAMPLE);

  // Program RAM write port; writes are only taken while the block is idle.
  always_ff @(posedge clock) begin
    if (prog_we && (r_state == S_IDLE)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Next-state, program counter and phase timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_led_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt = w_len_clamped;
          w_pc_nxt  = '0;
          if (w_len_clamped == '0) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = c_setup_ld;
          end
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = c_pulse_ld;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_gap_ld;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (w_is_store) begin
          // leds is captured on the way into SAMPLE so led_valid and the
          // new led_data appear together.
          w_state_nxt = S_SAMPLE;
          w_led_load  = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_SETUP;
          w_pc_nxt    = r_pc + AW'(1);
          w_cnt_nxt   = c_setup_ld;
        end
      end
      S_SAMPLE: begin
        if (w_last) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_SETUP;
          w_pc_nxt    = r_pc + AW'(1);
          w_cnt_nxt   = c_setup_ld;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers; async reset returns everything to idle at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_last_sw  <= '0;
      r_led_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_active) begin
        r_last_sw <= w_instr;
      end
      if (w_led_load) begin
        r_led_data <= leds;
      end
    end
  end

  // While stepping, switches track the RAM word at pc; otherwise hold the
  // last word presented.
  assign switches  = w_active ? w_instr : r_last_sw;
  assign button    = {(r_state == S_PULSE), 1'b0};
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign led_valid = (r_state == S_SAMPLE);
  assign led_data  = r_led_data;

endmodule
`default_nettype wire

// File: tb/tb_instr_step_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_step_driver
// Purpose  : Self-checking bench for instr_step_driver with a queue-based
//            reference model of the expected step sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_step_driver;

  localparam int AW        = 3;
  localparam int DEPTH     = 8;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 1;
  localparam int GAP_CYC   = 2;

  logic          clock;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          start2;
  logic [7:0]    switches,  switches2;
  logic [1:0]    button,    button2;
  logic [3:0]    leds,      leds2;
  logic          busy,      busy2;
  logic          done,      done2;
  logic          led_valid, led_valid2;
  logic [3:0]    led_data,  led_data2;

  logic [3:0]    mask;
  logic [7:0]    prog_m [DEPTH];
  int            n_vec;
  int            n_err;

  // Processor stand-in: leds echo the low nibble of the presented word.
  assign leds  = switches[3:0]  ^ mask;
  assign leds2 = switches2[3:0] ^ mask;

  instr_step_driver #(.AW(AW), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)) u_dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .switches(switches), .button(button), .leds(leds), .busy(busy),
    .done(done), .led_valid(led_valid), .led_data(led_data)
  );

  instr_step_driver #(.AW(AW), .SETUP_CYC(3), .PULSE_CYC(2), .GAP_CYC(4)) u_dut2 (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start2),
    .switches(switches2), .button(button2), .leds(leds2), .busy(busy2),
    .done(done2), .led_valid(led_valid2), .led_data(led_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = a[AW-1:0];
    prog_data = d;
    @(negedge clock);
    prog_we   = 1'b0;
    prog_m[a] = d;
  endtask

  // One run on u_dut, compared against a model built from prog_m.
  task automatic run(input string tag, input int len, input bit inject,
                     input bit wr0, input logic [7:0] wr0d);
    int eff, exp_busy, nb, ndone, done_idx, b0, glitch, stable, width;
    bit prev_b1, cur_b1, fin;
    logic [7:0] psw, sw0, exp_sw;
    logic [7:0] q_sw[$];
    int         q_w[$];
    int         q_st[$];
    logic [3:0] q_led[$];
    logic [3:0] e_led[$];
    eff = (len > DEPTH) ? DEPTH : len;
    @(negedge clock);
    sw0      = switches;
    prog_len = len[AW:0];
    start    = 1'b1;
    if (wr0) begin
      prog_we   = 1'b1;
      prog_addr = '0;
      prog_data = wr0d;
      prog_m[0] = wr0d;
    end
    @(negedge clock);
    start = 1'b0;
    prog_we = 1'b0;
    nb = 0; ndone = 0; done_idx = -1; b0 = 0; glitch = 0; stable = 0; width = 0;
    prev_b1 = 1'b0; fin = 1'b0; psw = sw0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge clock);
      if (inject && k == 5) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 8'hFF;
      end else if (inject && k == 6) begin
        start = 1'b0; prog_we = 1'b0;
      end
      cur_b1 = button[1];
      if (button[0]) b0++;
      if (prev_b1 && switches != psw) glitch++;
      if (cur_b1 && !prev_b1) begin
        q_sw.push_back(switches);
        q_st.push_back((switches == psw) ? stable : 0);
        width = 1;
      end else if (cur_b1) begin
        width++;
      end
      if (!cur_b1 && prev_b1) q_w.push_back(width);
      if (!cur_b1) stable = (switches == psw && !prev_b1) ? stable + 1 : 1;
      if (led_valid) q_led.push_back(led_data);
      if (done) begin ndone++; done_idx = k; end
      if (busy) nb++;
      else begin fin = 1'b1; break; end
      prev_b1 = cur_b1;
      psw     = switches;
    end
    start = 1'b0;
    prog_we = 1'b0;

    exp_busy = 1;
    for (int i = 0; i < eff; i++) begin
      exp_busy += SETUP_CYC + PULSE_CYC + GAP_CYC;
      if (prog_m[i][7:6] == 2'b01) begin
        exp_busy += 1;
        e_led.push_back(prog_m[i][3:0] ^ mask);
      end
    end
    exp_sw = (eff > 0) ? prog_m[eff-1] : sw0;

    chk({tag, "_term"}, fin, 1);
    chk({tag, "_npulse"}, q_sw.size(), eff);
    for (int i = 0; i < eff && i < q_sw.size(); i++) begin
      chk($sformatf("%s_sw%0d", tag, i), q_sw[i], prog_m[i]);
      chk($sformatf("%s_setup%0d", tag, i), q_st[i] >= SETUP_CYC, 1);
      if (i < q_w.size()) chk($sformatf("%s_width%0d", tag, i), q_w[i], PULSE_CYC);
    end
    chk({tag, "_nled"}, q_led.size(), e_led.size());
    for (int i = 0; i < e_led.size() && i < q_led.size(); i++)
      chk($sformatf("%s_led%0d", tag, i), q_led[i], e_led[i]);
    chk({tag, "_busy"}, nb, exp_busy);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_doneidx"}, done_idx, exp_busy - 1);
    chk({tag, "_btn0"}, b0, 0);
    chk({tag, "_glitch"}, glitch, 0);
    chk({tag, "_idle_sw"}, switches, exp_sw);
  endtask

  // Timing run on u_dut2 (setup 3, pulse 2, gap 4): a plain word then a store.
  task automatic run2();
    int rises[$];
    int nb, b1cnt, b0, nled, ndone;
    logic [3:0] ledv;
    bit prev, fin;
    wr(0, 8'h05);
    wr(1, 8'h45);
    @(negedge clock);
    prog_len = 2;
    start2   = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    nb = 0; b1cnt = 0; b0 = 0; nled = 0; ndone = 0; ledv = '0; prev = 1'b0; fin = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clock);
      if (button2[1] && !prev) rises.push_back(k);
      if (button2[1]) b1cnt++;
      if (button2[0]) b0++;
      if (led_valid2) begin nled++; ledv = led_data2; end
      if (done2) ndone++;
      prev = button2[1];
      if (busy2) nb++;
      else begin fin = 1'b1; break; end
    end
    chk("t6_term", fin, 1);
    chk("t6_nrise", rises.size(), 2);
    if (rises.size() >= 2) begin
      chk("t6_first_rise", rises[0], 3);
      chk("t6_instr_cycles", rises[1] - rises[0], 9);
    end
    chk("t6_b1_cycles", b1cnt, 4);
    chk("t6_btn0", b0, 0);
    chk("t6_busy", nb, 9 + 10 + 1);
    chk("t6_nled", nled, 1);
    chk("t6_led", ledv, 4'h5 ^ mask);
    chk("t6_ndone", ndone, 1);
  endtask

  // Stimulus sequence.
  initial begin
    logic [7:0] t2 [7];
    bit found;
    n_vec = 0; n_err = 0;
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; start2 = 1'b0; mask = 4'h0;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = '0;
    repeat (3) @(negedge clock);
    chk("rst_sw", switches, 0);
    chk("rst_btn", button, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lv", led_valid, 0);
    chk("rst_ld", led_data, 0);
    chk("rst_btn2", button2, 0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h00);

    // 1: two-word program, store echoes 1101
    mask = 4'h2;
    wr(0, 8'h0D); wr(1, 8'h4F);
    run("t1", 2, 0, 0, 8'h00);
    chk("t1_led_data", led_data, 4'b1101);

    // 6: alternate timing parameters
    run2();

    // 2: seven-word program
    t2 = '{8'h0D, 8'h4F, 8'h93, 8'h0A, 8'hD2, 8'hC3, 8'hC4};
    for (int i = 0; i < 7; i++) wr(i, t2[i]);
    run("t2", 7, 0, 0, 8'h00);

    // 3: zero-length program
    run("t3", 0, 0, 0, 8'h00);

    // 4: start/write while busy must be ignored
    run("t4", 7, 1, 0, 8'h00);
    run("t4_replay", 7, 0, 0, 8'h00);

    // 5: reset during a step pulse
    @(negedge clock);
    prog_len = 7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (button[1]) begin found = 1'b1; break; end
      @(negedge clock);
    end
    chk("t5_found_pulse", found, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_btn", button, 0);
    chk("t5_busy", busy, 0);
    chk("t5_sw", switches, 0);
    chk("t5_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    run("t5_rerun", 7, 0, 0, 8'h00);

    // start and write in the same idle cycle
    run("wr0", 3, 0, 1, 8'h4A);

    // randomized programs, lengths include 0 and clamped values
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom);
      for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
      run($sformatf("rnd%0d", r), $urandom_range(0, 15), 0,
          ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    run("clamp", 15, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
